sdram_init_seq: RTL and testbench

- Parametrised SDRAM power-up and initialisation sequencer.
- Sequence: power-up NOP wait → PRECHARGE ALL → N× AUTO REFRESH → LOAD MODE REGISTER → ready.
- Every JEDEC wait (tRP, tRC, tMRD, power-up) is a cycle-count parameter. Mode register fields are parameters. All DRAM outputs are registered.
- Owns the DRAM command bus until odram_ready. The main controller arbitrates afterwards; in the optional mode this block also requests periodic refresh.

---
 rtl/sdram_pkg.sv | 62 ++++++
 rtl/sdram_init_seq_wait_counter.sv | 40 ++++
 rtl/sdram_init_seq.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM initialisation sequencer.
//   - DRAM command encodings {CS_N, RAS_N, CAS_N, WE_N}
//   - One-hot FSM state encoding
//   - Mode register field positions, CAS latency constants
//   - mode_word(): builds the LOAD MODE address word from its fields
package sdram_pkg;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CmdNop = 4'b0111;
    localparam cmd_t CmdPre = 4'b0010;
    localparam cmd_t CmdRef = 4'b0001;
    localparam cmd_t CmdLmr = 4'b0000;

    // StAref/StAwrc are only reachable when periodic refresh is built in.
    typedef enum logic [9:0] {
        StPwrup = 10'b00_0000_0001,
        StPre   = 10'b00_0000_0010,
        StWrp   = 10'b00_0000_0100,
        StRef   = 10'b00_0000_1000,
        StWrc   = 10'b00_0001_0000,
        StMrs   = 10'b00_0010_0000,
        StWmrd  = 10'b00_0100_0000,
        StDone  = 10'b00_1000_0000,
        StAref  = 10'b01_0000_0000,
        StAwrc  = 10'b10_0000_0000
    } state_e;

    localparam int unsigned ModeBlLsb   = 0;
    localparam int unsigned ModeBtBit   = 3;
    localparam int unsigned ModeCasLsb  = 4;
    localparam int unsigned ModeWsBit   = 9;
    localparam int unsigned PreAllBit   = 10;

    localparam int unsigned CasLat2 = 2;
    localparam int unsigned CasLat3 = 3;

    function automatic logic [2:0] burst_len_code(input int unsigned bl);
        logic [2:0] code;
        case (bl)
            1:       code = 3'b000;
            2:       code = 3'b001;
            4:       code = 3'b010;
            8:       code = 3'b011;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    function automatic logic [11:0] mode_word(input int unsigned cl, input int unsigned bl,
                                              input int unsigned interleave,
                                              input int unsigned wsingle);
        logic [11:0] w;
        w                   = '0;
        w[ModeBlLsb +: 3]   = burst_len_code(bl);
        w[ModeBtBit]        = (interleave != 0);
        w[ModeCasLsb +: 3]  = 3'(cl);
        w[ModeWsBit]        = (wsingle != 0);
        return w;
    endfunction

endpackage

// File: rtl/sdram_init_seq_wait_counter.sv
// sdram_wait_counter: loadable down-counter used for every timed wait.
//   clk_i       clock
//   rst_i       asynchronous, active-high reset (counter <= ResetVal)
//   load_i      load strobe, takes priority over counting
//   load_val_i  value loaded on load_i
//   zero_o      counter value is zero
// The counter decrements once per cycle and parks at zero.
module sdram_wait_counter #(
    parameter int unsigned      Width    = 16,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up / initialisation sequencer.
// Sequence: power-up NOP wait -> PRECHARGE ALL -> INIT_REFRESHES x AUTO REFRESH ->
// LOAD MODE REGISTER -> odram_ready (sticky until reset).
// Ports:
//   iclk, ireset          clock, asynchronous active-high reset
//   odram_ready           initialisation complete
//   dram_clk              forwarded iclk
//   dram_cke/cs_n/ras_n/cas_n/we_n/addr/ba/dqm   registered DRAM command bus
//   odq_oe                DQ output enable, always 0
//   orefresh_req          periodic refresh request (optional feature)
//   irefresh_gnt          refresh grant from controller (optional feature)
// Optional feature macro: SDRAM_INIT_AUTOREFRESH_EN enables the periodic refresh requester.
//
// Timing model: the wait counter is loaded on the edge that enters a command state, so the
// command cycle itself counts towards the wait. A command state whose counter is already
// zero moves straight to the next command, giving back-to-back commands for a 1-cycle wait.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W           = 13,
    parameter int unsigned BA_W             = 2,
    parameter int unsigned T_POWERUP_CYC    = 20000,
    parameter int unsigned T_RP_CYC         = 2,
    parameter int unsigned T_RC_CYC         = 7,
    parameter int unsigned T_MRD_CYC        = 2,
    parameter int unsigned INIT_REFRESHES   = 8,
    parameter int unsigned CAS_LATENCY      = 2,
    parameter int unsigned BURST_LEN        = 1,
    parameter int unsigned BURST_INTERLEAVE = 0,
    parameter int unsigned WRITE_SINGLE     = 1,
    parameter int unsigned T_REFI_CYC       = 780
) (
    input  logic              iclk,
    input  logic              ireset,
    output logic              odram_ready,
    output logic              dram_clk,
    output logic              dram_cke,
    output logic              dram_cs_n,
    output logic              dram_ras_n,
    output logic              dram_cas_n,
    output logic              dram_we_n,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [BA_W-1:0]   dram_ba,
    output logic [1:0]        dram_dqm,
    output logic              odq_oe,
    output logic              orefresh_req,
    input  logic              irefresh_gnt
);

    if (!(CAS_LATENCY == CasLat2 || CAS_LATENCY == CasLat3)) begin : g_bad_cl
        $error("CAS_LATENCY must be 2 or 3");
    end
    if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_bl
        $error("BURST_LEN must be 1, 2, 4 or 8");
    end
    if (T_POWERUP_CYC < 1 || T_RP_CYC < 1 || T_RC_CYC < 1 || T_MRD_CYC < 1 ||
        T_REFI_CYC < 1) begin : g_bad_t
        $error("all T_*_CYC parameters must be >= 1");
    end
    if (INIT_REFRESHES < 1 || INIT_REFRESHES > 15) begin : g_bad_nref
        $error("INIT_REFRESHES must be in 1..15");
    end
    if (ADDR_W < 11) begin : g_bad_aw
        $error("ADDR_W must be >= 11 to carry A10");
    end

    localparam int unsigned CntMax = (T_POWERUP_CYC > T_REFI_CYC) ? T_POWERUP_CYC : T_REFI_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] PwrupLoad = CntW'(T_POWERUP_CYC - 1);
    localparam logic [CntW-1:0] RpLoad    = CntW'(T_RP_CYC - 1);
    localparam logic [CntW-1:0] RcLoad    = CntW'(T_RC_CYC - 1);
    localparam logic [CntW-1:0] MrdLoad   = CntW'(T_MRD_CYC - 1);

    localparam logic [4:0]        InitRefs    = 5'(INIT_REFRESHES);
    localparam logic [11:0]       ModeWord12  = mode_word(CAS_LATENCY, BURST_LEN,
                                                          BURST_INTERLEAVE, WRITE_SINGLE);
    localparam logic [ADDR_W-1:0] ModeAddr    = ADDR_W'(ModeWord12);
    localparam logic [ADDR_W-1:0] PreAllAddr  = ADDR_W'(1 << PreAllBit);

    state_e              state_q, state_d;
    logic                cnt_zero, cnt_load;
    logic [CntW-1:0]     cnt_load_val;
    logic [3:0]          refcnt_q, refcnt_d;
    logic                last_ref, refs_done;
    logic                svc_go;

    cmd_t                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BA_W-1:0]     ba_q, ba_d;
    logic [1:0]          dqm_q, dqm_d;
    logic                ready_q, ready_d;
    logic                cke_q;

    sdram_wait_counter #(
        .Width    (CntW),
        .ResetVal (PwrupLoad)
    ) u_wait_cnt (
        .clk_i      (iclk),
        .rst_i      (ireset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    // last_ref: the AUTO REFRESH being issued now is the final init refresh.
    assign last_ref  = ({1'b0, refcnt_q} + 5'd1) >= InitRefs;
    assign refs_done = {1'b0, refcnt_q} >= InitRefs;

    // State register
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q  <= StPwrup;
            refcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            refcnt_q <= refcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPwrup: if (cnt_zero) state_d = StPre;
            StPre:   state_d = cnt_zero ? StRef : StWrp;
            StWrp:   if (cnt_zero) state_d = StRef;
            StRef: begin
                if (!cnt_zero)     state_d = StWrc;
                else if (last_ref) state_d = StMrs;
                else               state_d = StRef;
            end
            StWrc:   if (cnt_zero) state_d = refs_done ? StMrs : StRef;
            StMrs:   state_d = cnt_zero ? StDone : StWmrd;
            StWmrd:  if (cnt_zero) state_d = StDone;
            StDone:  if (svc_go) state_d = StAref;
            // A pending grant at the end of tRC chains straight into the next refresh.
            StAref: begin
                if (!cnt_zero)   state_d = StAwrc;
                else if (svc_go) state_d = StAref;
                else             state_d = StDone;
            end
            StAwrc:  if (cnt_zero) state_d = svc_go ? StAref : StDone;
            default: state_d = StPwrup;
        endcase
    end

    always_comb begin
        refcnt_d = refcnt_q;
        if (state_q == StRef) begin
            refcnt_d = refcnt_q + 4'd1;
        end else if (state_q == StPwrup || state_q == StPre || state_q == StWrp) begin
            refcnt_d = '0;
        end
    end

    // Wait counter is (re)loaded on the edge entering each command state.
    always_comb begin
        cnt_load     = 1'b1;
        cnt_load_val = RcLoad;
        unique case (state_d)
            StPre:         cnt_load_val = RpLoad;
            StRef, StAref: cnt_load_val = RcLoad;
            StMrs:         cnt_load_val = MrdLoad;
            default:       cnt_load     = 1'b0;
        endcase
    end

    // Output logic: decoded from state_d so the registered bus lines up with state_q.
    always_comb begin
        cmd_d   = CmdNop;
        addr_d  = '0;
        ba_d    = '0;
        dqm_d   = 2'b11;
        ready_d = ready_q | (state_d == StDone);
        unique case (state_d)
            StPre: begin
                cmd_d  = CmdPre;
                addr_d = PreAllAddr;
            end
            StRef, StAref: cmd_d = CmdRef;
            StMrs: begin
                cmd_d  = CmdLmr;
                addr_d = ModeAddr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            cmd_q   <= CmdNop;
            addr_q  <= '0;
            ba_q    <= '0;
            dqm_q   <= 2'b11;
            ready_q <= 1'b0;
            cke_q   <= 1'b1;
        end else begin
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            dqm_q   <= dqm_d;
            ready_q <= ready_d;
            cke_q   <= 1'b1;
        end
    end

`ifdef SDRAM_INIT_AUTOREFRESH_EN
    localparam logic [CntW-1:0] RefiLoad = CntW'(T_REFI_CYC - 1);

    logic       refi_zero, refi_load, expire, take, req_q;
    logic [2:0] pend_q, pend_d;

    // Interval counter holds its reload value outside S_DONE and runs only in S_DONE.
    assign expire    = (state_q == StDone) & refi_zero;
    assign refi_load = (state_q != StDone) | refi_zero;
    assign take      = (state_d == StAref);
    assign svc_go    = irefresh_gnt & req_q;

    sdram_wait_counter #(
        .Width    (CntW),
        .ResetVal (RefiLoad)
    ) u_refi_cnt (
        .clk_i      (iclk),
        .rst_i      (ireset),
        .load_i     (refi_load),
        .load_val_i (RefiLoad),
        .zero_o     (refi_zero)
    );

    // Expiry and grant on the same edge cancel out, even when saturated.
    always_comb begin
        pend_d = pend_q;
        if (expire && !take) begin
            if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
        end else if (take && !expire) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            pend_q <= '0;
            req_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            req_q  <= (pend_d != 3'd0);
        end
    end

    assign orefresh_req = req_q;
`else
    logic unused_gnt;
    assign unused_gnt   = irefresh_gnt;
    assign svc_go       = 1'b0;
    assign orefresh_req = 1'b0;
`endif

    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;
    assign dram_addr   = addr_q;
    assign dram_ba     = ba_q;
    assign dram_dqm    = dqm_q;
    assign dram_cke    = cke_q;
    assign odram_ready = ready_q;
    assign dram_clk    = iclk;
    assign odq_oe      = 1'b0;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Testbench for sdram_init_seq. Three instances run side by side:
//   a: base timing (tRP=2, tRC=7, tMRD=2), CL2/BL1/WS1, T_REFI_CYC=20
//   b: CL3/BL8/interleaved/burst write
//   c: all post-command waits of 1 cycle
// Cycle N means N rising edges after reset release, sampled 1 time unit after the edge.
module tb_sdram_init_seq;

    localparam logic [3:0] CNop = 4'b0111;
    localparam logic [3:0] CPre = 4'b0010;
    localparam logic [3:0] CRef = 4'b0001;
    localparam logic [3:0] CLmr = 4'b0000;
    localparam int NTr = 85;
    localparam int NVec = 18;

    logic iclk = 1'b0;
    logic ireset = 1'b1;
    logic gnt = 1'b0;
    always #5 iclk = ~iclk;

    wire [2:0]       rdy, dclk, cke, cs_n, ras_n, cas_n, we_n, oe, req;
    wire [2:0][12:0] addr;
    wire [2:0][1:0]  ba, dqm;

    sdram_init_seq #(
        .T_POWERUP_CYC(10), .T_RP_CYC(2), .T_RC_CYC(7), .T_MRD_CYC(2), .INIT_REFRESHES(8),
        .CAS_LATENCY(2), .BURST_LEN(1), .BURST_INTERLEAVE(0), .WRITE_SINGLE(1), .T_REFI_CYC(20)
    ) u_a (
        .iclk(iclk), .ireset(ireset), .odram_ready(rdy[0]), .dram_clk(dclk[0]),
        .dram_cke(cke[0]), .dram_cs_n(cs_n[0]), .dram_ras_n(ras_n[0]), .dram_cas_n(cas_n[0]),
        .dram_we_n(we_n[0]), .dram_addr(addr[0]), .dram_ba(ba[0]), .dram_dqm(dqm[0]),
        .odq_oe(oe[0]), .orefresh_req(req[0]), .irefresh_gnt(gnt)
    );

    sdram_init_seq #(
        .T_POWERUP_CYC(10), .T_RP_CYC(2), .T_RC_CYC(7), .T_MRD_CYC(2), .INIT_REFRESHES(8),
        .CAS_LATENCY(3), .BURST_LEN(8), .BURST_INTERLEAVE(1), .WRITE_SINGLE(0), .T_REFI_CYC(20)
    ) u_b (
        .iclk(iclk), .ireset(ireset), .odram_ready(rdy[1]), .dram_clk(dclk[1]),
        .dram_cke(cke[1]), .dram_cs_n(cs_n[1]), .dram_ras_n(ras_n[1]), .dram_cas_n(cas_n[1]),
        .dram_we_n(we_n[1]), .dram_addr(addr[1]), .dram_ba(ba[1]), .dram_dqm(dqm[1]),
        .odq_oe(oe[1]), .orefresh_req(req[1]), .irefresh_gnt(1'b0)
    );

    sdram_init_seq #(
        .T_POWERUP_CYC(10), .T_RP_CYC(1), .T_RC_CYC(1), .T_MRD_CYC(1), .INIT_REFRESHES(8),
        .CAS_LATENCY(2), .BURST_LEN(1), .BURST_INTERLEAVE(0), .WRITE_SINGLE(1), .T_REFI_CYC(20)
    ) u_c (
        .iclk(iclk), .ireset(ireset), .odram_ready(rdy[2]), .dram_clk(dclk[2]),
        .dram_cke(cke[2]), .dram_cs_n(cs_n[2]), .dram_ras_n(ras_n[2]), .dram_cas_n(cas_n[2]),
        .dram_we_n(we_n[2]), .dram_addr(addr[2]), .dram_ba(ba[2]), .dram_dqm(dqm[2]),
        .odq_oe(oe[2]), .orefresh_req(req[2]), .irefresh_gnt(1'b0)
    );

    typedef struct {
        int         inst;
        int         cyc;
        logic [3:0] cmd;
        logic [1:0] ba;
        logic [12:0] addr;
        logic       ready;
    } vec_t;

    vec_t vecs [NVec];

    logic [3:0]  tr_cmd  [3][NTr+1];
    logic [12:0] tr_addr [3][NTr+1];
    logic [1:0]  tr_ba   [3][NTr+1];
    logic        tr_rdy  [3][NTr+1];
    int          misc_bad [3];

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;

    function automatic logic [3:0] cmd_of(input int i);
        return {cs_n[i], ras_n[i], cas_n[i], we_n[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        ireset = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        ireset = 1'b0;
        cyc = 0;
    endtask

    task automatic run_trace();
        for (int i = 0; i < 3; i++) misc_bad[i] = 0;
        for (int c = 1; c <= NTr; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                tr_cmd[i][cyc]  = cmd_of(i);
                tr_addr[i][cyc] = addr[i];
                tr_ba[i][cyc]   = ba[i];
                tr_rdy[i][cyc]  = rdy[i];
                if (dqm[i] !== 2'b11 || cke[i] !== 1'b1 || oe[i] !== 1'b0 || req[i] !== 1'b0)
                    misc_bad[i]++;
            end
        end
    endtask

    task automatic check_trace(input string tag);
        int nref;
        int pos_bad;
        for (int k = 0; k < NVec; k++) begin
            check($sformatf("%s_vec%0d_i%0d_c%0d", tag, k, vecs[k].inst, vecs[k].cyc),
                  32'({tr_cmd[vecs[k].inst][vecs[k].cyc], tr_ba[vecs[k].inst][vecs[k].cyc],
                       tr_addr[vecs[k].inst][vecs[k].cyc], tr_rdy[vecs[k].inst][vecs[k].cyc]}),
                  32'({vecs[k].cmd, vecs[k].ba, vecs[k].addr, vecs[k].ready}));
        end
        for (int i = 0; i < 3; i++) begin
            nref = 0;
            pos_bad = 0;
            for (int c = 1; c <= NTr; c++) begin
                if (tr_cmd[i][c] == CRef) begin
                    if (i == 0 && c != 12 + 7 * nref) pos_bad++;
                    if (i == 2 && c != 11 + nref) pos_bad++;
                    nref++;
                end
            end
            check($sformatf("%s_refcount_i%0d", tag, i), 32'(nref), 32'd8);
            check($sformatf("%s_refpos_i%0d", tag, i), 32'(pos_bad), 32'd0);
            check($sformatf("%s_dqm_cke_oe_req_i%0d", tag, i), 32'(misc_bad[i]), 32'd0);
        end
    endtask

    initial begin
        int n;
        int bad;
        logic r333, r334;

        vecs[0]  = '{0,  9, CNop, 2'd0, 13'h000, 1'b0};
        vecs[1]  = '{0, 10, CPre, 2'd0, 13'h400, 1'b0};
        vecs[2]  = '{0, 11, CNop, 2'd0, 13'h000, 1'b0};
        vecs[3]  = '{0, 12, CRef, 2'd0, 13'h000, 1'b0};
        vecs[4]  = '{0, 19, CRef, 2'd0, 13'h000, 1'b0};
        vecs[5]  = '{0, 61, CRef, 2'd0, 13'h000, 1'b0};
        vecs[6]  = '{0, 62, CNop, 2'd0, 13'h000, 1'b0};
        vecs[7]  = '{0, 68, CLmr, 2'd0, 13'h220, 1'b0};
        vecs[8]  = '{0, 69, CNop, 2'd0, 13'h000, 1'b0};
        vecs[9]  = '{0, 70, CNop, 2'd0, 13'h000, 1'b1};
        vecs[10] = '{0, 85, CNop, 2'd0, 13'h000, 1'b1};
        vecs[11] = '{1, 68, CLmr, 2'd0, 13'h03B, 1'b0};
        vecs[12] = '{1, 70, CNop, 2'd0, 13'h000, 1'b1};
        vecs[13] = '{2, 10, CPre, 2'd0, 13'h400, 1'b0};
        vecs[14] = '{2, 11, CRef, 2'd0, 13'h000, 1'b0};
        vecs[15] = '{2, 18, CRef, 2'd0, 13'h000, 1'b0};
        vecs[16] = '{2, 19, CLmr, 2'd0, 13'h220, 1'b0};
        vecs[17] = '{2, 20, CNop, 2'd0, 13'h000, 1'b1};

        // Reset values
        repeat (2) @(posedge iclk);
        #1;
        check("rst_cmd", 32'(cmd_of(0)), 32'(CNop));
        check("rst_addr_ba", 32'({ba[0], addr[0]}), 32'd0);
        check("rst_dqm", 32'(dqm[0]), 32'd3);
        check("rst_cke_oe", 32'({cke[0], oe[0]}), 32'b10);
        check("rst_ready_req", 32'({rdy[0], req[0]}), 32'd0);
        check("dram_clk_fwd", 32'(dclk[0]), 32'(iclk));

        // Full sequence on all three instances
        do_reset();
        run_trace();
        check_trace("run1");

        // Reset during the 5th AUTO REFRESH wait, then a clean restart
        do_reset();
        while (cyc < 40) step();
        check("t3_ref5", 32'(cmd_of(0)), 32'(CRef));
        while (cyc < 43) step();
        ireset = 1'b1;
        #1;
        check("t3_rst_cmd_rdy", 32'({cmd_of(0), rdy[0]}), 32'({CNop, 1'b0}));
        @(posedge iclk);
        #1;
        check("t3_next_edge", 32'({cmd_of(0), rdy[0], dqm[0]}), 32'({CNop, 1'b0, 2'b11}));
        do_reset();
        run_trace();
        check_trace("run2");

        // Asynchronous reset drops a sticky ready without waiting for an edge
        ireset = 1'b1;
        #1;
        check("async_rdy_clear", 32'({rdy[0], rdy[2]}), 32'd0);

`ifdef SDRAM_INIT_AUTOREFRESH_EN
        // Pending saturates at 7 with no grant, then 7 back-to-back refreshes
        do_reset();
        while (cyc < 89) step();
        check("ar_req_before", 32'(req[0]), 32'd0);
        step();
        check("ar_req_first", 32'(req[0]), 32'd1);
        while (cyc < 291) step();
        gnt = 1'b1;
        n = 0;
        bad = 0;
        r333 = 1'b0;
        r334 = 1'b1;
        while (cyc < 355) begin
            step();
            if (cmd_of(0) == CRef) begin
                if (cyc != 292 + 7 * n) bad++;
                n++;
            end
            if (cyc == 333) r333 = req[0];
            if (cyc == 334) r334 = req[0];
        end
        gnt = 1'b0;
        check("ar_refcount", 32'(n), 32'd7);
        check("ar_refpos", 32'(bad), 32'd0);
        check("ar_req_333", 32'(r333), 32'd1);
        check("ar_req_334", 32'(r334), 32'd0);
        check("ar_ready_held", 32'(rdy[0]), 32'd1);

        // Interval expiry coincides with a grant
        while (cyc < 380) step();
        check("sim_req_before", 32'(req[0]), 32'd1);
        gnt = 1'b1;
        step();
        check("sim_ref", 32'({cmd_of(0), req[0]}), 32'({CRef, 1'b1}));
        gnt = 1'b0;
        step();
        check("sim_after", 32'({cmd_of(0), req[0]}), 32'({CNop, 1'b1}));
        n = 0;
        while (cyc < 400) begin
            step();
            if (cmd_of(0) == CRef) n++;
        end
        check("sim_no_extra_ref", 32'(n), 32'd0);
        check("sim_req_held", 32'(req[0]), 32'd1);
`else
        // Without the feature the grant is ignored and no request is raised
        do_reset();
        while (cyc < 75) step();
        gnt = 1'b1;
        n = 0;
        bad = 0;
        while (cyc < 115) begin
            step();
            if (cmd_of(0) != CNop) n++;
            if (req[0] !== 1'b0) bad++;
        end
        gnt = 1'b0;
        check("noar_no_cmds", 32'(n), 32'd0);
        check("noar_req_zero", 32'(bad), 32'd0);
        check("noar_ready", 32'(rdy[0]), 32'd1);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
